// File: rtl/add_mul_comp_seq.sv
`default_nettype none
// ============================================================================
// Module      : add_mul_comp_seq
// Description : Sequential add / multiply / compare unit with valid/ready
//               handshakes on both sides. Two unsigned WIDTH-bit operands are
//               compared. Auto mode returns the product when a > b and the
//               sum otherwise. The product comes from an iterative
//               shift-add engine.
//
//   Parameters
//     WIDTH      operand width (2..32); result is 2*WIDTH bits
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     in_valid   operands/mode valid         in_ready  accepting (IDLE only)
//     a, b       unsigned operands (b is the multiplier)
//     mode       00 auto, 01 add, 10 mul, 11 compare only
//     out_valid  result valid                out_ready consumer accepts
//     result     sum, product or compare word (2*WIDTH bits)
//     gt         captured a > b              did_mul   result is a product
//
//   Optional feature macro
//     ADD_MUL_COMP_EARLY_TERM_EN : the multiply loop stops once the remaining
//                                  multiplier is zero. Results are unchanged;
//                                  only latency differs.
//
// Revision    : 1.0 - initial release
// ============================================================================
module add_mul_comp_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               gt,
  output logic               did_mul
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] MODE_AUTO = 2'b00;
  localparam logic [1:0] MODE_MUL  = 2'b10;
  localparam logic [1:0] MODE_CMP  = 2'b11;

  logic [1:0]         state;
  logic [1:0]         state_next;

  // The multiplicand register also holds operand a for the add path, and the
  // multiplier register holds operand b; neither moves outside MUL.
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         mode_q;

  logic               gt_in;
  logic               go_mul;
  logic               mul_last;
  logic [2*WIDTH-1:0] acc_next;

  assign gt_in    = (a > b);
  assign go_mul   = (mode == MODE_MUL) || ((mode == MODE_AUTO) && gt_in);
  assign acc_next = acc + (mplier[0] ? mcand : '0);

`ifdef ADD_MUL_COMP_EARLY_TERM_EN
  // Stop after the iteration whose shift leaves the multiplier empty; the
  // counter bound is kept as a backstop.
  assign mul_last = (mplier[WIDTH-1:1] == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
  assign mul_last = (cnt == CNT_W'(WIDTH - 1));
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_next = go_mul ? S_MUL : S_ADD;
        end
      end
      S_ADD: state_next = S_DONE;
      S_MUL: begin
        if (mul_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Only a presented result can be drained; an early out_ready does
        // not shorten latency.
        if (out_valid && out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (from the state register only)
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready = (state == S_IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      mode_q    <= '0;
      result    <= '0;
      gt        <= 1'b0;
      did_mul   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            mode_q  <= mode;
            acc     <= '0;
            cnt     <= '0;
            gt      <= gt_in;
            did_mul <= go_mul;
          end
        end
        S_ADD: begin
          if (mode_q == MODE_CMP) begin
            result <= {{(2*WIDTH-1){1'b0}}, gt};
          end else begin
            result <= {{(WIDTH-1){1'b0}},
                       ({1'b0, mcand[WIDTH-1:0]} + {1'b0, mplier})};
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            result <= acc_next;
          end
        end
        S_DONE: begin
          // First DONE cycle presents the result; it is then held until the
          // consumer takes it.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
